reduce_issue_scheduler: RTL and testbench

REDUCE_ISSUE_SCHEDULER -- requirements
Module: reduce_issue_scheduler

---
 rtl/reduce_pkg.sv | 33 +++
 rtl/reduce_issue_scheduler_if.sv | 35 +++
 rtl/reduce_res_fifo.sv | 65 ++++++
 rtl/reduce_issue_scheduler.sv | 148 ++++++++++++++
 tb/tb_reduce_issue_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared constants for the reduce issue scheduler: op encodings,
// packet field positions and default widths.
package reduce_pkg;

    localparam int REDUCE_LATENCY   = 13;
    localparam int REDUCE_DATA_W    = 32;
    localparam int REDUCE_TAG_W     = 4;
    localparam int REDUCE_NUM_REQ   = 4;
    localparam int REDUCE_RES_DEPTH = 16;

    localparam int PKT_A_LSB  = 0;
    localparam int PKT_A_MSB  = 31;
    localparam int PKT_OP_LSB = 32;
    localparam int PKT_OP_MSB = 36;
    localparam int OP_W       = PKT_OP_MSB - PKT_OP_LSB + 1;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 5'h00,
        OP_SUB = 5'h01,
        OP_AND = 5'h02,
        OP_OR  = 5'h03,
        OP_XOR = 5'h04,
        OP_MIN = 5'h05,
        OP_MAX = 5'h06,
        OP_SHL = 5'h07,
        OP_SHR = 5'h08
    } reduce_op_e;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reduce_issue_scheduler_if.sv
// Requester and result-FIFO bus of the reduce issue scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface reduce_issue_scheduler_if
    import reduce_pkg::*;
#(
    parameter int NUM_REQ = REDUCE_NUM_REQ,
    parameter int DATA_W  = REDUCE_DATA_W,
    parameter int TAG_W   = REDUCE_TAG_W
);
    localparam int PORT_W = port_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_grant;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [PORT_W-1:0] res_port;
    logic              res_ready;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, res_ready,
        input  req_grant, res_valid, res_data, res_tag, res_port
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, res_ready,
        output req_grant, res_valid, res_data, res_tag, res_port
    );

endinterface

// File: rtl/reduce_res_fifo.sv
// Synchronous result FIFO with occupancy count; pointers wrap at DEPTH,
// so DEPTH need not be a power of two.
module reduce_res_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    // A pop frees the head slot, so a push into a full FIFO is legal then.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= inc(r_wptr);
            if (w_do_pop)  r_rptr <= inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(i_push && w_full && !w_do_pop)
    );

endmodule

// File: rtl/reduce_issue_scheduler.sv
// Round-robin issue of reduce ops to a fixed-latency ALU with credit-checked
// result FIFO. Define REDUCE_SCHED_STATS_EN for issue/stall counters.
module reduce_issue_scheduler
    import reduce_pkg::*;
#(
    parameter int NUM_REQ   = REDUCE_NUM_REQ,
    parameter int LATENCY   = REDUCE_LATENCY,
    parameter int DATA_W    = REDUCE_DATA_W,
    parameter int TAG_W     = REDUCE_TAG_W,
    parameter int RES_DEPTH = REDUCE_RES_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    reduce_issue_scheduler_if.slave bus,
    output logic                   o_alu_valid,
    output logic [OP_W-1:0]        o_alu_op,
    output logic [DATA_W-1:0]      o_alu_a,
    output logic [DATA_W-1:0]      o_alu_b,
    input  logic [DATA_W-1:0]      i_alu_result
`ifdef REDUCE_SCHED_STATS_EN
    ,
    output logic [31:0]            o_stat_issue,
    output logic [31:0]            o_stat_stall
`endif
);

    localparam int PORT_W = port_w(NUM_REQ);
    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
    localparam int ENT_W  = DATA_W + TAG_W + PORT_W;

    logic [PORT_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]   r_inflight;
    logic [LATENCY-1:0] r_sv;
    logic [TAG_W-1:0]   r_stag  [LATENCY];
    logic [PORT_W-1:0]  r_sport [LATENCY];
    logic [OP_W-1:0]    r_alu_op;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;

    logic               w_hit;
    logic               w_credit;
    logic               w_fire;
    logic               w_cap;
    logic               w_pop;
    logic               w_res_valid;
    logic [PORT_W-1:0]  w_gidx;
    logic [PORT_W-1:0]  w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [CNT_W-1:0]   w_count;
    logic [ENT_W-1:0]   w_head;

    // Stage 0 of the tracker is the issue register, so a granted op is
    // counted as in flight from the very next cycle.
    assign w_credit = ({1'b0, r_inflight} + {1'b0, w_count})
                      < (CNT_W + 1)'(RES_DEPTH);

    always_comb begin
        w_hit  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_hit && bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_hit  = 1'b1;
                w_gidx = PORT_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_grant    = (w_hit && w_credit && !rst)
                        ? (NUM_REQ'(1) << w_gidx) : '0;
    assign w_fire     = |w_grant;
    assign w_next_ptr = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
    assign w_cap      = r_sv[LATENCY-1];
    assign w_pop      = w_res_valid && bus.res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_sv       <= '0;
            r_inflight <= '0;
        end else begin
            if (w_fire) r_rr_ptr <= w_next_ptr;
            r_sv <= {r_sv[LATENCY-2:0], w_fire};
            case ({w_fire, w_cap})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_alu_op <= bus.req_op[int'(w_gidx)*OP_W +: OP_W];
            r_alu_a  <= bus.req_a[int'(w_gidx)*DATA_W +: DATA_W];
            r_alu_b  <= bus.req_b[int'(w_gidx)*DATA_W +: DATA_W];
        end
        r_stag[0]  <= bus.req_tag[int'(w_gidx)*TAG_W +: TAG_W];
        r_sport[0] <= w_gidx;
        for (int s = 1; s < LATENCY; s++) begin
            r_stag[s]  <= r_stag[s-1];
            r_sport[s] <= r_sport[s-1];
        end
    end

    reduce_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cap),
        .i_data  ({r_sport[LATENCY-1], r_stag[LATENCY-1], i_alu_result}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_res_valid),
        .o_count (w_count)
    );

    assign bus.req_grant = w_grant;
    assign bus.res_valid = w_res_valid;
    assign {bus.res_port, bus.res_tag, bus.res_data} = w_head;

    assign o_alu_valid = r_sv[0];
    assign o_alu_op    = r_alu_op;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;

`ifdef REDUCE_SCHED_STATS_EN
    logic [31:0] r_stat_issue;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issue <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_fire && !(&r_stat_issue))
                r_stat_issue <= r_stat_issue + 1'b1;
            if ((|bus.req_valid) && !w_credit && !(&r_stat_stall))
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign o_stat_issue = r_stat_issue;
    assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_reduce_issue_scheduler.sv
// Scoreboard bench for reduce_issue_scheduler with a behavioural
// fixed-latency ALU; build with REDUCE_SCHED_STATS_EN to cover the counters.
module tb_reduce_issue_scheduler;
    import reduce_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = 13;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 16;
    localparam int PW    = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [PW-1:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    logic          alu_valid;
    logic [4:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
`ifdef REDUCE_SCHED_STATS_EN
    logic [31:0]   stat_issue;
    logic [31:0]   stat_stall;
`endif

    reduce_issue_scheduler_if #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) bus ();

    reduce_issue_scheduler #(
        .NUM_REQ(N), .LATENCY(LAT), .DATA_W(DW), .TAG_W(TW), .RES_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_alu_valid  (alu_valid),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
`ifdef REDUCE_SCHED_STATS_EN
        ,
        .o_stat_issue (stat_issue),
        .o_stat_stall (stat_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_fn(input logic [4:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

    // External ALU: issue registers are the first of LAT stages.
    logic [DW-1:0] pipe [LAT-1];
    always @(posedge clk) begin
        pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign alu_result = pipe[LAT-2];

    logic          pend;
    logic [4:0]    p_op;
    logic [DW-1:0] p_a;
    logic [DW-1:0] p_b;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("issue_valid", 64'(alu_valid), 1);
                chk("issue_op", 64'(alu_op), 64'(p_op));
                chk("issue_a", 64'(alu_a), 64'(p_a));
                chk("issue_b", 64'(alu_b), 64'(p_b));
            end else begin
                chk("idle_valid", 64'(alu_valid), 0);
            end
            pend = 1'b0;
            chk("grant_onehot", 64'($onehot0(bus.req_grant)), 1);
            if (bus.res_valid && bus.res_ready) begin
                chk("res_expected", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("res_data", 64'(bus.res_data), 64'(e.d));
                    chk("res_tag", 64'(bus.res_tag), 64'(e.t));
                    chk("res_port", 64'(bus.res_port), 64'(e.p));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_grant[i]) begin
                    p_op = bus.req_op[i*5 +: 5];
                    p_a  = bus.req_a[i*DW +: DW];
                    p_b  = bus.req_b[i*DW +: DW];
                    e.d  = alu_fn(p_op, p_a, p_b);
                    e.t  = bus.req_tag[i*TW +: TW];
                    e.p  = PW'(i);
                    q.push_back(e);
                    pend = 1'b1;
                end
            end
        end
    end

    logic [4:0] ops [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int i, input logic [4:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [TW-1:0] tag);
        bus.req_valid[i]       = 1'b1;
        bus.req_op[i*5 +: 5]   = op;
        bus.req_a[i*DW +: DW]  = a;
        bus.req_b[i*DW +: DW]  = b;
        bus.req_tag[i*TW +: TW] = tag;
    endtask

    task automatic set_all(input int c);
        for (int i = 0; i < N; i++)
            set_req(i, ops[(c + i) % 4], $urandom, $urandom, TW'(c + i));
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        bus.res_ready = 1'b1;
        for (int k = 0; k < 200 && q.size() != 0; k++) step();
        chk("drain_empty", 64'(q.size()), 0);
    endtask

    initial begin
        int lat;
        int run;
        int gcnt;
        logic [N-1:0] last_g;
        logic seen;

        ops[0] = OP_ADD;
        ops[1] = OP_SUB;
        ops[2] = OP_XOR;
        ops[3] = OP_OR;
        bus.req_valid = '1;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b0;

        // Reset state, with every requester asking
        step();
        @(negedge clk);
        chk("rst_grant", 64'(bus.req_grant), 0);
        chk("rst_res_valid", 64'(bus.res_valid), 0);
        chk("rst_alu_valid", 64'(alu_valid), 0);

        // Single request: grant, issue at +1, result at +14
        do_reset();
        set_req(2, OP_ADD, 3, 4, 5);
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t1_grant", 64'(bus.req_grant), 64'(4'b0100));
        step();
        idle();
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("t1_issue", 64'(alu_valid), 1);
            if (bus.res_valid) begin
                lat = k;
                break;
            end
            step();
        end
        chk("t1_latency", 64'(lat), 14);
        chk("t1_data", 64'(bus.res_data), 7);
        chk("t1_tag", 64'(bus.res_tag), 5);
        chk("t1_port", 64'(bus.res_port), 2);
        step();
        @(negedge clk);
        chk("t1_popped", 64'(bus.res_valid), 0);
        drain();

        // All four requesting: strict rotation, gapless results
        do_reset();
        bus.res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            set_all(c);
            @(negedge clk);
            chk("t2_grant", 64'(bus.req_grant), 64'(N'(1) << (c % 4)));
            step();
        end
        idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.res_valid) break;
            step();
        end
        run = 0;
        while (bus.res_valid && run < 20) begin
            run++;
            step();
            @(negedge clk);
        end
        chk("t2_run", 64'(run), 12);
        drain();

        // Consumer stalled: credit limits grants to the FIFO depth
        do_reset();
        bus.res_ready = 1'b0;
        gcnt = 0;
        last_g = '0;
        for (int c = 0; c < 36; c++) begin
            set_all(c);
            @(negedge clk);
            if (|bus.req_grant) gcnt++;
            last_g = bus.req_grant;
            step();
        end
        chk("t3_grants", 64'(gcnt), 16);
        chk("t3_blocked", 64'(last_g), 0);
        idle();
        @(negedge clk);
        chk("t3_fifo_full", 64'(dut.u_fifo.r_count), 16);
        chk("t3_inflight", 64'(dut.r_inflight), 0);
`ifdef REDUCE_SCHED_STATS_EN
        chk("stat_issue", 64'(stat_issue), 16);
        chk("stat_stall", 64'(stat_stall), 20);
`endif
        step();
        bus.res_ready = 1'b1;
        @(negedge clk);
        step();
        bus.res_ready = 1'b0;
        gcnt = 0;
        for (int c = 0; c < 20; c++) begin
            set_all(c + 40);
            @(negedge clk);
            if (|bus.req_grant) gcnt++;
            step();
        end
        chk("t3_regrant", 64'(gcnt), 1);
        idle();
        @(negedge clk);
        chk("t3_refill", 64'(dut.u_fifo.r_count), 16);
        drain();

        // Reset with a full pipeline discards everything in flight
        do_reset();
        bus.res_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            set_all(c + 80);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_grant", 64'(bus.req_grant), 0);
        chk("t4_rst_res", 64'(bus.res_valid), 0);
        chk("t4_rst_alu", 64'(alu_valid), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_inflight", 64'(dut.r_inflight), 0);
        chk("t4_first_grant", 64'(bus.req_grant), 1);
        step();
        idle();
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
            step();
        end
        chk("t4_quiet", 64'(seen), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_bad);
        $fatal(1);
    end

endmodule
